systolic_seq_ctrl: RTL and testbench
====================================

Name: systolic_seq_ctrl

Overview:
Sequencing controller for the 8x8 weight-stationary systolic array. It accepts a job command, streams ARRAY_SIZE weight beats into the array through write/row_ptr, then streams activation rows. It tracks each row through the array with a token delay line and presents results on a valid/ready stream. Output backpressure stalls the whole array via enable.

Parameters:
ARRAY_SIZE, 8, array dimension: weight beats per job and lanes per beat.
DATA_WIDTH, 8, signed weight/activation width.
ACC_WIDTH, 32, signed result width.
MAX_ROWS, 256, maximum activation rows per job.
PIPE_LAT, 16, enabled cycles from an activation row at arr_a_in to its result at arr_c_out; must be >= 1.

Ports:
clk  in  1  clock
rst  in  1  async active-high reset
start  in  1  job request; sampled only in IDLE
num_rows  in  $clog2(MAX_ROWS+1)  activation rows M for the job (0..MAX_ROWS)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job completion
w_valid  in  1  weight beat valid
w_ready  out  1  weight beat accepted when w_valid && w_ready
w_data  in  ARRAY_SIZE x DATA_WIDTH  one weight beat (unpacked, signed)
act_valid  in  1  activation row valid
act_ready  out  1  activation row accepted when act_valid && act_ready
act_data  in  ARRAY_SIZE x DATA_WIDTH  one activation row
res_valid  out  1  result row valid
res_ready  in  1  result consumer ready
res_data  out  ARRAY_SIZE x ACC_WIDTH  result row (= arr_c_out)
res_last  out  1  qualifies the final result row of the job
arr_enable  out  1  to array enable
arr_write  out  1  to array write
arr_row_ptr  out  $clog2(ARRAY_SIZE)  to array row_ptr
arr_b_in  out  ARRAY_SIZE x DATA_WIDTH  to array b_in
arr_a_in  out  ARRAY_SIZE x DATA_WIDTH  to array a_in
arr_c_out  in  ARRAY_SIZE x ACC_WIDTH  from array c_out

Behaviour:
- Reset (async, any state): state=IDLE; counters, token line and rows_left cleared. Outputs: busy=0, done=0, w_ready=0, act_ready=0, res_valid=0, res_last=0, arr_write=0, arr_row_ptr=0, arr_enable=0.
- stall = res_valid && !res_ready. In LOAD_W/STREAM/DRAIN, arr_enable = !stall; in IDLE, arr_enable=0.
- IDLE: start=1 -> latch rows_left=num_rows, wcnt=0 -> LOAD_W. start in any other state is ignored.
- LOAD_W: w_ready=1. arr_write = w_valid; arr_row_ptr=wcnt; arr_b_in=w_data (combinational pass-through). Each accepted beat increments wcnt. The accepted beat with wcnt==ARRAY_SIZE-1 goes to STREAM if rows_left>0, otherwise to IDLE with done=1 the next cycle. The pipeline is empty here, so no stall is possible.
- STREAM: act_ready = !stall && rows_left>0.
  - Accepted row: arr_a_in=act_data, push token 1 (plus a last flag when rows_left==1), decrement rows_left.
  - No row accepted while enabled: arr_a_in=0, push token 0 (bubble).
  - When rows_left reaches 0 -> DRAIN.
  - arr_write=0 throughout STREAM and DRAIN.
- Token line: PIPE_LAT-deep shift register of {valid,last}. It advances only when arr_enable=1; contents are frozen during stall.
- Result stream: res_valid = tail valid token; res_last = tail last flag; res_data = arr_c_out. A held result stays stable until res_ready.
- DRAIN: arr_a_in=0, push bubbles. When the result with res_last is handshaken -> IDLE; done=1 for one cycle; busy falls the same cycle state enters IDLE.
- Arithmetic: no width conversion; data passes through unchanged. The controller never modifies values.
- rows_left never underflows. act_ready=0 outside STREAM. w_ready=0 outside LOAD_W.

Test Plan:
- Basic job: M=3, 8 back-to-back weight beats (values r*8+c) then 3 back-to-back rows, res_ready=1 -> arr_write high 8 cycles with row_ptr 0..7 and b_in matching; results valid exactly PIPE_LAT=16 cycles after each row; res_last on the 3rd; done one cycle after that handshake.
- Bubbles: act_valid toggles 1,0,1,0 for M=2 -> results spaced 2 cycles apart; no res_valid on bubble slots.
- Backpressure: res_ready=0 for 5 cycles on the 1st result of M=4 -> arr_enable=0 and act_ready=0 for those 5 cycles; res_data held; all 4 results delivered in order with no loss.
- M=0: start, then 8 weight beats -> no act_ready ever, done pulses one cycle after the 8th beat, busy falls.
- Start while busy: pulse start mid-STREAM with num_rows=9 -> ignored; the original M=3 completes with exactly 3 results.
- Reset mid-STREAM: assert rst after 1 of 3 rows -> all outputs go to their reset values immediately; a new M=1 job afterwards produces exactly 1 result.

Source files
------------

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the weight-stationary systolic array: loads ARRAY_SIZE weight beats,
// streams activation rows, tracks them with a token line and emits results on valid/ready.
module systolic_seq_lane #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                         load_en,
    input  logic                         act_en,
    input  logic signed [DATA_WIDTH-1:0] w_lane,
    input  logic signed [DATA_WIDTH-1:0] act_lane,
    output logic signed [DATA_WIDTH-1:0] b_lane,
    output logic signed [DATA_WIDTH-1:0] a_lane
);
    assign b_lane = load_en ? w_lane : '0;
    assign a_lane = act_en ? act_lane : '0;
endmodule

module systolic_seq_ctrl #(
    parameter int ARRAY_SIZE = 8,
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int MAX_ROWS   = 256,
    parameter int PIPE_LAT   = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [$clog2(MAX_ROWS+1)-1:0]       num_rows,
    output logic                                busy,
    output logic                                done,
    input  logic                                w_valid,
    output logic                                w_ready,
    input  logic signed [DATA_WIDTH-1:0]        w_data [ARRAY_SIZE],
    input  logic                                act_valid,
    output logic                                act_ready,
    input  logic signed [DATA_WIDTH-1:0]        act_data [ARRAY_SIZE],
    output logic                                res_valid,
    input  logic                                res_ready,
    output logic signed [ACC_WIDTH-1:0]         res_data [ARRAY_SIZE],
    output logic                                res_last,
    output logic                                arr_enable,
    output logic                                arr_write,
    output logic [$clog2(ARRAY_SIZE)-1:0]       arr_row_ptr,
    output logic signed [DATA_WIDTH-1:0]        arr_b_in [ARRAY_SIZE],
    output logic signed [DATA_WIDTH-1:0]        arr_a_in [ARRAY_SIZE],
    input  logic signed [ACC_WIDTH-1:0]         arr_c_out [ARRAY_SIZE]
);
    localparam int RW = $clog2(MAX_ROWS+1);
    localparam int WW = $clog2(ARRAY_SIZE);

    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;

    state_t            state;
    logic [RW-1:0]     rows_left;
    logic [WW-1:0]     wcnt;
    logic [PIPE_LAT:1] vld_pipe;
    logic [PIPE_LAT:1] last_pipe;
    logic              stall, act_fire, w_fire;

    // Tail of the token line is the row currently at arr_c_out.
    assign res_valid   = vld_pipe[PIPE_LAT];
    assign res_last    = last_pipe[PIPE_LAT];
    assign res_data    = arr_c_out;
    assign stall       = res_valid && !res_ready;
    assign arr_enable  = (state != IDLE) && !stall;
    assign act_ready   = (state == STREAM) && !stall && (rows_left != '0);
    assign act_fire    = act_valid && act_ready;
    assign w_fire      = w_valid && w_ready;
    assign arr_write   = w_fire;
    assign arr_row_ptr = wcnt;

    for (genvar i = 0; i < ARRAY_SIZE; i++) begin : g_lane
        systolic_seq_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
            .load_en (w_ready),
            .act_en  (act_fire),
            .w_lane  (w_data[i]),
            .act_lane(act_data[i]),
            .b_lane  (arr_b_in[i]),
            .a_lane  (arr_a_in[i])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rows_left <= '0;
            wcnt      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            w_ready   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    rows_left <= num_rows;
                    wcnt      <= '0;
                    state     <= LOAD_W;
                    busy      <= 1'b1;
                    w_ready   <= 1'b1;
                end
                LOAD_W: if (w_fire) begin
                    wcnt <= wcnt + WW'(1);
                    if (wcnt == WW'(ARRAY_SIZE-1)) begin
                        w_ready <= 1'b0;
                        if (rows_left != '0) begin
                            state <= STREAM;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                STREAM: if (act_fire) begin
                    rows_left <= rows_left - RW'(1);
                    if (rows_left == RW'(1)) state <= DRAIN;
                end
                DRAIN: if (res_valid && res_ready && res_last) begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tokens freeze with the array so they stay aligned with its contents under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            last_pipe <= '0;
        end else if (arr_enable) begin
            for (int i = PIPE_LAT; i > 1; i--) begin
                vld_pipe[i]  <= vld_pipe[i-1];
                last_pipe[i] <= last_pipe[i-1];
            end
            vld_pipe[1]  <= act_fire;
            last_pipe[1] <= act_fire && (rows_left == RW'(1));
        end
    end
endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Randomized scoreboard bench for systolic_seq_ctrl with a behavioural array model.
module tb_systolic_seq_ctrl;
    localparam int N  = 8;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int MR = 256;
    localparam int PL = 16;
    localparam int RW = $clog2(MR+1);

    typedef logic signed [DW-1:0] row_t [N];
    typedef row_t                 mat_t [N];
    typedef logic signed [AW-1:0] res_t [N];
    typedef struct { res_t data; bit last; longint due; } exp_t;

    logic            clk, rst, start, busy, done;
    logic [RW-1:0]   num_rows;
    logic            w_valid, w_ready, act_valid, act_ready;
    logic            res_valid, res_ready, res_last;
    logic            arr_enable, arr_write;
    logic [$clog2(N)-1:0] arr_row_ptr;
    row_t            w_data, act_data, arr_b_in, arr_a_in;
    res_t            res_data, arr_c_out;

    systolic_seq_ctrl #(.ARRAY_SIZE(N), .DATA_WIDTH(DW), .ACC_WIDTH(AW),
                        .MAX_ROWS(MR), .PIPE_LAT(PL)) dut (
        .clk(clk), .rst(rst), .start(start), .num_rows(num_rows),
        .busy(busy), .done(done),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_last(res_last), .arr_enable(arr_enable), .arr_write(arr_write),
        .arr_row_ptr(arr_row_ptr), .arr_b_in(arr_b_in), .arr_a_in(arr_a_in),
        .arr_c_out(arr_c_out)
    );

    int     n_checks = 0, n_fail = 0;
    longint cyc = 0;
    exp_t   exp_q [$];
    bit     chk_lat, rand_rr, bp_arm, saw_act_ready;
    int     cur_m, rows_acc, hs_count;
    longint last_hs_cyc;
    mat_t   wmat;

    // Row-times-matrix product: what the array computes for one activation row.
    function automatic res_t mm(row_t a, mat_t w);
        res_t r;
        int   s;
        for (int j = 0; j < N; j++) begin
            s = 0;
            for (int k = 0; k < N; k++) s += int'(a[k]) * int'(w[k][j]);
            r[j] = s;
        end
        return r;
    endfunction

    function automatic bit eq_res(res_t a, res_t b);
        for (int i = 0; i < N; i++) if (a[i] != b[i]) return 0;
        return 1;
    endfunction

    function automatic bit eq_row(row_t a, row_t b);
        for (int i = 0; i < N; i++) if (a[i] != b[i]) return 0;
        return 1;
    endfunction

    task automatic chk(input bit ok, input string name, input longint got, input longint want);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Array stand-in: captures weights from the write port, delays rows PL enabled cycles.
    mat_t emu_w;
    row_t emu_a [PL];
    always @(posedge clk) begin
        if (arr_write) emu_w[arr_row_ptr] <= arr_b_in;
        if (arr_enable) begin
            emu_a[0] <= arr_a_in;
            for (int i = 1; i < PL; i++) emu_a[i] <= emu_a[i-1];
        end
    end
    always_comb arr_c_out = mm(emu_a[PL-1], emu_w);

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    initial forever begin
        @(posedge clk);
        cyc++;
    end
    initial begin
        #500000;
        $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
        $fatal(1, "timeout");
    end

    // Scoreboard push: expected result computed from stimulus weights and the accepted row.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (act_ready) saw_act_ready = 1;
                if (act_valid && act_ready) begin
                    rows_acc++;
                    e.data = mm(act_data, wmat);
                    e.last = (rows_acc == cur_m);
                    e.due  = chk_lat ? cyc + PL : -1;
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: pops on each result handshake and checks hold-under-stall.
    initial begin
        exp_t e;
        bit   prev_stall, prev_l;
        res_t prev_d;
        prev_stall = 0;
        forever begin
            @(negedge clk);
            if (rst) prev_stall = 0;
            else begin
                if (prev_stall)
                    chk(res_valid && eq_res(res_data, prev_d) && res_last == prev_l,
                        "res_hold", res_data[0], prev_d[0]);
                if (res_valid && res_ready) begin
                    hs_count++;
                    last_hs_cyc = cyc;
                    if (exp_q.size() == 0) chk(0, "unexpected_res", res_data[0], 0);
                    else begin
                        e = exp_q.pop_front();
                        chk(eq_res(res_data, e.data), "res_data", res_data[0], e.data[0]);
                        chk(res_last == e.last, "res_last", res_last, e.last);
                        if (e.due >= 0) chk(cyc == e.due, "res_latency", cyc, e.due);
                    end
                end
                prev_stall = res_valid && !res_ready;
                prev_d     = res_data;
                prev_l     = res_last;
            end
        end
    end

    // Result consumer: always ready, random, or one 5-cycle stall on the first result.
    initial begin
        res_t held;
        res_ready = 1;
        forever begin
            @(posedge clk);
            #1;
            if (rand_rr) res_ready = ($urandom_range(0, 3) != 0);
            else if (bp_arm && res_valid) begin
                bp_arm    = 0;
                res_ready = 0;
                held      = res_data;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk(!arr_enable, "bp_arr_enable", arr_enable, 0);
                    chk(!act_ready, "bp_act_ready", act_ready, 0);
                    chk(eq_res(res_data, held), "bp_res_held", res_data[0], held[0]);
                    @(posedge clk);
                    #1;
                end
                res_ready = 1;
            end else res_ready = 1;
        end
    end

    task automatic chk_reset(input string tag);
        chk(!busy, {tag, "_busy"}, busy, 0);
        chk(!done, {tag, "_done"}, done, 0);
        chk(!w_ready, {tag, "_w_ready"}, w_ready, 0);
        chk(!act_ready, {tag, "_act_ready"}, act_ready, 0);
        chk(!res_valid, {tag, "_res_valid"}, res_valid, 0);
        chk(!res_last, {tag, "_res_last"}, res_last, 0);
        chk(!arr_write, {tag, "_arr_write"}, arr_write, 0);
        chk(arr_row_ptr == 0, {tag, "_row_ptr"}, arr_row_ptr, 0);
        chk(!arr_enable, {tag, "_arr_enable"}, arr_enable, 0);
    endtask

    // mode: 0 back-to-back, 1 bubbles, 2 backpressure, 3 start while busy, 4 random.
    // stop_after >= 0 abandons the job once that many rows were accepted.
    task automatic do_job(input int m, input int mode, input int stop_after);
        longint acc_cyc;
        row_t   a;
        int     guard;
        chk_lat = (mode == 0 || mode == 1 || mode == 3);
        rand_rr = (mode == 4);
        bp_arm  = (mode == 2);
        cur_m = m; rows_acc = 0; hs_count = 0; saw_act_ready = 0;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                wmat[r][c] = (mode == 0) ? DW'(r * N + c) : DW'($urandom);
        start = 1; num_rows = RW'(m);
        @(posedge clk); #1;
        start = 0;
        for (int r = 0; r < N; r++) begin
            w_valid = 1; w_data = wmat[r];
            guard = 0;
            @(negedge clk);
            while (!w_ready && guard < 20) begin @(negedge clk); guard++; end
            chk(w_ready, "w_ready", w_ready, 1);
            chk(arr_write && arr_row_ptr == r && eq_row(arr_b_in, w_data),
                "w_load", arr_row_ptr, r);
            acc_cyc = cyc;
            @(posedge clk); #1;
            w_valid = 0;
        end
        for (int i = 0; i < m; i++) begin
            if (i == stop_after) return;
            if (mode == 4) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            for (int c = 0; c < N; c++) a[c] = DW'($urandom);
            act_valid = 1; act_data = a;
            if (mode == 3 && i == 1) begin start = 1; num_rows = RW'(9); end
            guard = 0;
            @(negedge clk);
            while (!act_ready && guard < 300) begin @(negedge clk); guard++; end
            chk(act_ready, "act_ready_wait", act_ready, 1);
            @(posedge clk); #1;
            act_valid = 0; start = 0;
            if (mode == 1) begin @(posedge clk); #1; end
        end
        guard = 0;
        @(negedge clk);
        while (!done && guard < 400) begin @(negedge clk); guard++; end
        chk(done, "done_wait", done, 1);
        if (m > 0) chk(cyc == last_hs_cyc + 1, "done_after_last", cyc, last_hs_cyc + 1);
        else       chk(cyc == acc_cyc + 1, "done_after_load", cyc, acc_cyc + 1);
        chk(!busy, "busy_fall", busy, 0);
        chk(hs_count == m, "res_count", hs_count, m);
        chk(exp_q.size() == 0, "exp_empty", exp_q.size(), 0);
        if (m == 0) chk(!saw_act_ready, "no_act_ready", saw_act_ready, 0);
        @(negedge clk);
        chk(!done, "done_pulse", done, 0);
        rand_rr = 0; chk_lat = 0;
    endtask

    initial begin
        rst = 1; start = 0; num_rows = '0; w_valid = 0; act_valid = 0;
        for (int c = 0; c < N; c++) begin w_data[c] = '0; act_data[c] = '0; end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("reset");
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;

        do_job(3, 0, -1);
        do_job(2, 1, -1);
        do_job(4, 2, -1);
        do_job(0, 0, -1);
        do_job(3, 3, -1);

        do_job(3, 0, 1);
        rst = 1;
        #1;
        chk_reset("mid_reset");
        exp_q.delete();
        @(posedge clk); #1;
        rst = 0;
        @(posedge clk); #1;
        do_job(1, 0, -1);

        for (int j = 0; j < 4; j++) do_job($urandom_range(1, 6), 4, -1);
        do_job(20, 4, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
